// File: rtl/regfile_write_sequencer_pkg.sv
// regfile_write_sequencer_pkg: shared op classes, default addresses and FSM state codes
package regfile_write_sequencer_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_CLRF, OP_CLRW, OP_MOVWF, OP_BXF, OP_FSZ, OP_MOVF, OP_ALUXLW, OP_ELSE
  } op_class_e;
  localparam int INDF_DEF   = 0;
  localparam int STATUS_DEF = 3;
  localparam int FSR_DEF    = 4;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
endpackage

// File: rtl/regfile_write_decode.sv
// regfile_write_decode: class/target/data decode with STATUS flag merge for one captured instruction
module regfile_write_decode
  import regfile_write_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int FLAG_WIDTH  = 3,
  parameter int Z_BIT       = 2,
  parameter int INDF_ADDR   = INDF_DEF,
  parameter int STATUS_ADDR = STATUS_DEF,
  parameter int FSR_ADDR    = FSR_DEF
) (
  input  op_class_e               cls,
  input  logic                    ir_d,
  input  logic [ADDR_WIDTH-1:0]   ir_addr,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic [FLAG_WIDTH-1:0]   alu_flags,
  input  logic [DATA_WIDTH-1:0]   w_in,
  input  logic [DATA_WIDTH-1:0]   status_in,
  input  logic [DATA_WIDTH-1:0]   fsr_in,
  output logic                    file_we,
  output logic [ADDR_WIDTH-1:0]   target,
  output logic [DATA_WIDTH-1:0]   file_data,
  output logic                    gpr_we,
  output logic                    fsr_we,
  output logic                    status_we,
  output logic [DATA_WIDTH-1:0]   status_wdata,
  output logic                    w_we,
  output logic [DATA_WIDTH-1:0]   w_wdata
);
  localparam logic [DATA_WIDTH-1:0] ZMASK = DATA_WIDTH'(1) << Z_BIT;
  logic dual, z_cls, f_cls, to_status;
  logic [DATA_WIDTH-1:0] raw, base, flag_data;
  always_comb begin
    dual = cls inside {OP_FSZ, OP_MOVF, OP_ELSE};
    z_cls = cls inside {OP_CLRF, OP_CLRW};
    f_cls = cls inside {OP_MOVF, OP_ALUXLW, OP_ELSE};
    target = (ir_addr == ADDR_WIDTH'(INDF_ADDR)) ? fsr_in[ADDR_WIDTH-1:0] : ir_addr;
    file_we = ((cls inside {OP_CLRF, OP_MOVWF, OP_BXF}) || (dual && ir_d)) && target != ADDR_WIDTH'(INDF_ADDR);
    raw = (cls == OP_CLRF) ? '0 : (cls == OP_MOVWF) ? w_in : alu_result;
    to_status = file_we && target == ADDR_WIDTH'(STATUS_ADDR);
    // A file write to STATUS becomes the base that the flag update merges into
    base = to_status ? raw : status_in;
    flag_data = z_cls ? (base | ZMASK) : f_cls ? {base[DATA_WIDTH-1:FLAG_WIDTH], alu_flags} : base;
    file_data = to_status ? flag_data : raw;
    status_we = to_status || z_cls || f_cls;
    status_wdata = flag_data;
    fsr_we = file_we && target == ADDR_WIDTH'(FSR_ADDR);
    gpr_we = file_we && !to_status && !fsr_we;
    w_we = (cls inside {OP_CLRW, OP_ALUXLW}) || (dual && !ir_d);
    w_wdata = (cls == OP_CLRW) ? '0 : alu_result;
  end
endmodule

// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer: captures an issued instruction, resolves it, then emits one cycle of write strobes
module regfile_write_sequencer
  import regfile_write_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int FLAG_WIDTH  = 3,
  parameter int Z_BIT       = 2,
  parameter int INDF_ADDR   = INDF_DEF,
  parameter int STATUS_ADDR = STATUS_DEF,
  parameter int FSR_ADDR    = FSR_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  op_class_e             op_class,
  input  logic                  ir_d,
  input  logic [ADDR_WIDTH-1:0] ir_addr,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [FLAG_WIDTH-1:0] alu_flags,
  input  logic [DATA_WIDTH-1:0] w_in,
  input  logic [DATA_WIDTH-1:0] status_in,
  input  logic [DATA_WIDTH-1:0] fsr_in,
  output logic                  gpr_we,
  output logic [ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0] gpr_wdata,
  output logic                  status_we,
  output logic [DATA_WIDTH-1:0] status_wdata,
  output logic                  fsr_we,
  output logic [DATA_WIDTH-1:0] fsr_wdata,
  output logic                  w_we,
  output logic [DATA_WIDTH-1:0] w_wdata,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data
);
  logic [1:0] state_q, state_d;
  logic ready_q, ready_d, take, load;
  op_class_e cls_q, cls_d;
  logic d_q, d_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [FLAG_WIDTH-1:0] flags_q, flags_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d, w_q, w_d, st_q, st_d, fsr_q, fsr_d;
  logic dec_file_we, dec_gpr_we, dec_fsr_we, dec_status_we, dec_w_we;
  logic [ADDR_WIDTH-1:0] dec_target;
  logic [DATA_WIDTH-1:0] dec_file_data, dec_status_wdata, dec_w_wdata;
  logic gpr_we_q, gpr_we_d, status_we_q, status_we_d, fsr_we_q, fsr_we_d, w_we_q, w_we_d;
  logic [ADDR_WIDTH-1:0] gpr_waddr_q, gpr_waddr_d;
  logic [DATA_WIDTH-1:0] gpr_wdata_q, gpr_wdata_d, status_wdata_q, status_wdata_d;
  logic [DATA_WIDTH-1:0] fsr_wdata_q, fsr_wdata_d, w_wdata_q, w_wdata_d;

  regfile_write_decode #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FLAG_WIDTH(FLAG_WIDTH), .Z_BIT(Z_BIT),
    .INDF_ADDR(INDF_ADDR), .STATUS_ADDR(STATUS_ADDR), .FSR_ADDR(FSR_ADDR)
  ) u_decode (
    .cls(cls_q), .ir_d(d_q), .ir_addr(addr_q), .alu_result(alu_q), .alu_flags(flags_q),
    .w_in(w_q), .status_in(st_q), .fsr_in(fsr_q),
    .file_we(dec_file_we), .target(dec_target), .file_data(dec_file_data),
    .gpr_we(dec_gpr_we), .fsr_we(dec_fsr_we), .status_we(dec_status_we),
    .status_wdata(dec_status_wdata), .w_we(dec_w_we), .w_wdata(dec_w_wdata)
  );

  always_comb begin
    take = issue_valid && ready_q;
    state_d = take ? ST_RESOLVE : (state_q == ST_RESOLVE) ? ST_COMMIT : ST_IDLE;
    ready_d = state_d != ST_RESOLVE;
    cls_d = take ? op_class : cls_q;
    d_d = take ? ir_d : d_q;
    addr_d = take ? ir_addr : addr_q;
    flags_d = take ? alu_flags : flags_q;
    alu_d = take ? alu_result : alu_q;
    w_d = take ? w_in : w_q;
    st_d = take ? status_in : st_q;
    fsr_d = take ? fsr_in : fsr_q;
    // Output registers load only on the RESOLVE->COMMIT edge, so strobes last exactly one cycle
    load = state_q == ST_RESOLVE;
    gpr_we_d = load && dec_gpr_we;
    gpr_waddr_d = gpr_we_d ? dec_target : '0;
    gpr_wdata_d = gpr_we_d ? dec_file_data : '0;
    status_we_d = load && dec_status_we;
    status_wdata_d = status_we_d ? dec_status_wdata : '0;
    fsr_we_d = load && dec_fsr_we;
    fsr_wdata_d = fsr_we_d ? dec_file_data : '0;
    w_we_d = load && dec_w_we;
    w_wdata_d = w_we_d ? dec_w_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      cls_q <= OP_NOP;
      d_q <= 1'b0;
      addr_q <= '0;
      flags_q <= '0;
      alu_q <= '0;
      w_q <= '0;
      st_q <= '0;
      fsr_q <= '0;
      gpr_we_q <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
      status_we_q <= 1'b0;
      status_wdata_q <= '0;
      fsr_we_q <= 1'b0;
      fsr_wdata_q <= '0;
      w_we_q <= 1'b0;
      w_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cls_q <= cls_d;
      d_q <= d_d;
      addr_q <= addr_d;
      flags_q <= flags_d;
      alu_q <= alu_d;
      w_q <= w_d;
      st_q <= st_d;
      fsr_q <= fsr_d;
      gpr_we_q <= gpr_we_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
      status_we_q <= status_we_d;
      status_wdata_q <= status_wdata_d;
      fsr_we_q <= fsr_we_d;
      fsr_wdata_q <= fsr_wdata_d;
      w_we_q <= w_we_d;
      w_wdata_q <= w_wdata_d;
    end
  end

  assign issue_ready = ready_q;
  assign gpr_we = gpr_we_q;
  assign gpr_waddr = gpr_waddr_q;
  assign gpr_wdata = gpr_wdata_q;
  assign status_we = status_we_q;
  assign status_wdata = status_wdata_q;
  assign fsr_we = fsr_we_q;
  assign fsr_wdata = fsr_wdata_q;
  assign w_we = w_we_q;
  assign w_wdata = w_wdata_q;
  // Captured operands stay stable through RESOLVE and COMMIT, so forwarding decodes them directly
  assign fwd_valid = (state_q != ST_IDLE) && dec_file_we;
  assign fwd_addr = fwd_valid ? dec_target : '0;
  assign fwd_data = fwd_valid ? dec_file_data : '0;
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// tb_regfile_write_sequencer: directed vectors with hand-computed write strobes and forwarding
module tb_regfile_write_sequencer;
  import regfile_write_sequencer_pkg::*;
  logic clk = 1'b0;
  logic rst_n, issue_valid, issue_ready, ir_d;
  op_class_e op_class;
  logic [4:0] ir_addr, gpr_waddr, fwd_addr;
  logic [7:0] alu_result, w_in, status_in, fsr_in;
  logic [2:0] alu_flags;
  logic gpr_we, status_we, fsr_we, w_we, fwd_valid;
  logic [7:0] gpr_wdata, status_wdata, fsr_wdata, w_wdata, fwd_data;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  regfile_write_sequencer dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op_class(op_class), .ir_d(ir_d), .ir_addr(ir_addr), .alu_result(alu_result),
    .alu_flags(alu_flags), .w_in(w_in), .status_in(status_in), .fsr_in(fsr_in),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .status_we(status_we), .status_wdata(status_wdata), .fsr_we(fsr_we), .fsr_wdata(fsr_wdata),
    .w_we(w_we), .w_wdata(w_wdata), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Drives one instruction, returns at the negedge inside RESOLVE with inputs scrambled
  task automatic issue(input op_class_e c, input logic d, input logic [4:0] a, input logic [7:0] alu,
                       input logic [2:0] fl, input logic [7:0] w, input logic [7:0] st, input logic [7:0] fs);
    int k = 0;
    while (!issue_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("issue_wait", issue_ready, 1);
    op_class = c; ir_d = d; ir_addr = a; alu_result = alu; alu_flags = fl;
    w_in = w; status_in = st; fsr_in = fs; issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0; op_class = OP_CLRF; ir_d = ~d; ir_addr = ~a; alu_result = ~alu;
    alu_flags = ~fl; w_in = ~w; status_in = ~st; fsr_in = ~fs;
  endtask

  task automatic resolve_chk(input string tag, input logic fv, input logic [4:0] fa, input logic [7:0] fd);
    check({tag, ".r_ready"}, issue_ready, 0);
    check({tag, ".r_strobes"}, {gpr_we, status_we, fsr_we, w_we}, 0);
    check({tag, ".r_fv"}, fwd_valid, fv);
    if (fv) begin
      check({tag, ".r_fa"}, fwd_addr, fa);
      check({tag, ".r_fd"}, fwd_data, fd);
    end
  endtask

  task automatic commit_chk(input string tag, input logic fv,
                            input logic gwe, input logic [4:0] ga, input logic [7:0] gd,
                            input logic swe, input logic [7:0] sd, input logic fwe, input logic [7:0] fd,
                            input logic wwe, input logic [7:0] wd);
    @(negedge clk);
    check({tag, ".c_ready"}, issue_ready, 1);
    check({tag, ".c_fv"}, fwd_valid, fv);
    check({tag, ".c_gpr"}, {gpr_we, gpr_waddr, gpr_wdata}, {gwe, ga, gd});
    check({tag, ".c_status"}, {status_we, status_wdata}, {swe, sd});
    check({tag, ".c_fsr"}, {fsr_we, fsr_wdata}, {fwe, fd});
    check({tag, ".c_w"}, {w_we, w_wdata}, {wwe, wd});
    @(negedge clk);
    check({tag, ".idle_we"}, {gpr_we, status_we, fsr_we, w_we, fwd_valid}, 0);
    check({tag, ".idle_data"}, {gpr_waddr, gpr_wdata, status_wdata, fsr_wdata, w_wdata}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; op_class = OP_NOP; ir_d = 1'b0; ir_addr = '0;
    alu_result = '0; alu_flags = '0; w_in = '0; status_in = '0; fsr_in = '0;
    repeat (2) @(negedge clk);
    check("rst.ready", issue_ready, 0);
    check("rst.outs", {gpr_we, status_we, fsr_we, w_we, fwd_valid, gpr_wdata, status_wdata, w_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.ready_rise", issue_ready, 1);

    issue(OP_MOVWF, 1, 5'h10, 8'h00, 3'b000, 8'h5A, 8'h00, 8'h00);
    resolve_chk("movwf", 1, 5'h10, 8'h5A);
    commit_chk("movwf", 1, 1, 5'h10, 8'h5A, 0, 0, 0, 0, 0, 0);

    issue(OP_ELSE, 1, 5'h00, 8'h00, 3'b100, 8'h00, 8'h18, 8'h07);
    resolve_chk("else_ind", 1, 5'h07, 8'h00);
    commit_chk("else_ind", 1, 1, 5'h07, 8'h00, 1, 8'h1C, 0, 0, 0, 0);

    issue(OP_CLRF, 1, 5'h03, 8'h66, 3'b011, 8'h00, 8'hFF, 8'h00);
    resolve_chk("clrf_st", 1, 5'h03, 8'h04);
    commit_chk("clrf_st", 1, 0, 0, 0, 1, 8'h04, 0, 0, 0, 0);

    issue(OP_MOVWF, 1, 5'h00, 8'h00, 3'b000, 8'h77, 8'h00, 8'h00);
    resolve_chk("ind_indf", 0, 0, 0);
    commit_chk("ind_indf", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    issue(OP_MOVF, 0, 5'h12, 8'h33, 3'b011, 8'h00, 8'h80, 8'h00);
    resolve_chk("movf_w", 0, 0, 0);
    commit_chk("movf_w", 0, 0, 0, 0, 1, 8'h83, 0, 0, 1, 8'h33);

    issue(OP_BXF, 0, 5'h04, 8'h1F, 3'b111, 8'h00, 8'h55, 8'h00);
    resolve_chk("bxf_fsr", 1, 5'h04, 8'h1F);
    commit_chk("bxf_fsr", 1, 0, 0, 0, 0, 0, 1, 8'h1F, 0, 0);

    issue(OP_CLRW, 1, 5'h10, 8'h99, 3'b000, 8'h00, 8'h01, 8'h00);
    resolve_chk("clrw", 0, 0, 0);
    commit_chk("clrw", 0, 0, 0, 0, 1, 8'h05, 0, 0, 1, 8'h00);

    issue(OP_ELSE, 1, 5'h03, 8'hA8, 3'b001, 8'h00, 8'h00, 8'h00);
    resolve_chk("else_st", 1, 5'h03, 8'hA9);
    commit_chk("else_st", 1, 0, 0, 0, 1, 8'hA9, 0, 0, 0, 0);

    issue(OP_ALUXLW, 1, 5'h10, 8'h3C, 3'b010, 8'h00, 8'hE0, 8'h00);
    resolve_chk("aluxlw", 0, 0, 0);
    commit_chk("aluxlw", 0, 0, 0, 0, 1, 8'hE2, 0, 0, 1, 8'h3C);

    issue(OP_FSZ, 1, 5'h00, 8'h42, 3'b111, 8'h00, 8'h07, 8'hFF);
    resolve_chk("fsz_ind", 1, 5'h1F, 8'h42);
    commit_chk("fsz_ind", 1, 1, 5'h1F, 8'h42, 0, 0, 0, 0, 0, 0);

    issue(OP_NOP, 1, 5'h10, 8'h42, 3'b111, 8'h11, 8'h07, 8'h00);
    resolve_chk("nop", 0, 0, 0);
    commit_chk("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Held issue_valid: accepts every other cycle, strobes one cycle each
    op_class = OP_MOVWF; ir_d = 1'b1; ir_addr = 5'h11; w_in = 8'h22; fsr_in = 8'h00; issue_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("b2b.ready%0d", k), issue_ready, (k % 2 == 0));
      check($sformatf("b2b.gpr%0d", k), {gpr_we, gpr_wdata}, (k % 2 == 0) ? 9'h122 : 9'h000);
    end
    issue_valid = 1'b0;
    @(negedge clk);
    check("b2b.tail", {gpr_we, issue_ready}, 2'b01);

    // Reset in RESOLVE discards the pending write
    issue(OP_MOVWF, 1, 5'h15, 8'h00, 3'b000, 8'hC3, 8'h00, 8'h00);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstr.ready", issue_ready, 0);
    check("rstr.outs", {gpr_we, gpr_waddr, gpr_wdata, fwd_valid, status_we, w_we}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstr.ready_rise", issue_ready, 1);
    check("rstr.no_strobe1", {gpr_we, fwd_valid}, 0);
    @(negedge clk);
    check("rstr.no_strobe2", {gpr_we, gpr_wdata}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_write_sequencer.md
# regfile_write_sequencer

Parametrised, registered successor to the combinational register-file write decision logic of the PIC16C5x core. It accepts one decoded instruction's execute class and operands per issue handshake and resolves indirect (INDF/FSR) addressing. It then emits single-cycle, mutually consistent write strobes for the GPR file, STATUS, FSR and W. It also presents a forwarding port so the operand-read path sees a pending write before it lands. It sits between the execute decoder / ALU and the register file, replacing the per-Q-state write decode.

## Interface
Parameters:
- DATA_WIDTH, 8, register/ALU data width
- ADDR_WIDTH, 5, file-register address width
- FLAG_WIDTH, 3, ALU status flags (C, DC, Z) occupying STATUS[FLAG_WIDTH-1:0]
- Z_BIT, 2, index of Z within STATUS
- INDF_ADDR, 0, indirect-access address
- STATUS_ADDR, 3, STATUS register address
- FSR_ADDR, 4, FSR register address

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  sequencer can accept
- op_class  in  4  execute class (package enum)
- ir_d  in  1  destination bit (1 = file, 0 = W)
- ir_addr  in  ADDR_WIDTH  file operand address
- alu_result  in  DATA_WIDTH  ALU result
- alu_flags  in  FLAG_WIDTH  ALU flags
- w_in  in  DATA_WIDTH  current W
- status_in  in  DATA_WIDTH  current STATUS
- fsr_in  in  DATA_WIDTH  current FSR
- gpr_we / gpr_waddr / gpr_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  GPR write
- status_we / status_wdata  out  1 / DATA_WIDTH  STATUS write
- fsr_we / fsr_wdata  out  1 / DATA_WIDTH  FSR write
- w_we / w_wdata  out  1 / DATA_WIDTH  W write
- fwd_valid / fwd_addr / fwd_data  out  1 / ADDR_WIDTH / DATA_WIDTH  pending file write

## Operation
- op_class values: NOP, CLRF, CLRW, MOVWF, BXF, FSZ, MOVF, ALUXLW, ELSE.
- All inputs are captured on the accepting edge (issue_valid && issue_ready). The captured values are used for the whole operation.
- States: IDLE -> RESOLVE -> COMMIT -> IDLE, or COMMIT -> RESOLVE when a new issue is accepted in COMMIT.
- RESOLVE: compute the target address. If ir_addr == INDF_ADDR, target = fsr_in[ADDR_WIDTH-1:0]. An indirect target that is itself INDF_ADDR suppresses the file write (result discarded).
- File data by class:
  - CLRF: 0.
  - MOVWF: w_in.
  - BXF: alu_result.
  - FSZ / MOVF / ELSE with ir_d = 1: alu_result.
  - FSZ / MOVF / ELSE with ir_d = 0: data goes to W instead.
  - ALUXLW and CLRW always write W. CLRW writes W = 0.
- Flags:
  - CLRF and CLRW set STATUS[Z_BIT] = 1 and keep all other bits.
  - MOVF, ALUXLW and ELSE write {status_in[DATA_WIDTH-1:FLAG_WIDTH], alu_flags}.
  - Other classes do not touch STATUS.
- Routing a file write by target:
  - STATUS_ADDR goes out on the status port.
  - FSR_ADDR goes out on the fsr port.
  - Any other target goes out on the gpr port.
  - At most one of gpr_we / status_we / fsr_we fires per instruction from the file write. A flag update may add status_we.
- STATUS collision: a file write to STATUS by a flag-affecting class produces a single status write. Data = file data with bits [FLAG_WIDTH-1:0] replaced by the new flags. CLRF to STATUS yields only Z set.
- NOP: no strobes.

## Timing
- Reset (rst_n low at a clk edge): state IDLE; pending operation discarded, no strobe. All outputs are 0, including issue_ready, fwd_valid and every *_we and data bus. issue_ready rises on the first edge with rst_n high.
- issue_ready = 1 in IDLE and COMMIT; 0 in RESOLVE. Sustained throughput is one instruction per 2 cycles.
- Latency: write strobes are high for exactly the one cycle in COMMIT. COMMIT is the second cycle after the accepting edge. Strobes and data are registered outputs; the data buses return to 0 when the strobes are low.
- fwd_valid is high in RESOLVE and COMMIT when a file write is pending (gpr, status or fsr target). fwd_addr is the resolved target; fwd_data is the final written value, including any STATUS merge.
- An issue accepted in COMMIT captures its operands on that edge. The register-file values it sees are pre-commit; the upstream read path must use the forwarding port.

## Structure
- Shared package holds: the op_class enum, the default address constants (INDF, STATUS, FSR) and the state enum.
- One sub-module, regfile_write_decode: the combinational class/target/data/merge decode used in RESOLVE. The top module holds the FSM, capture registers and output registers.

## Test plan
- MOVWF, ir_addr=0x10, w_in=0x5A -> in COMMIT: gpr_we=1, addr 0x10, data 0x5A; status_we=0; fwd_valid high for 2 cycles.
- ELSE, ir_d=1, ir_addr=0, fsr_in=0x07, alu_result=0x00, alu_flags=3'b100, status_in=0x18 -> gpr write to 0x07 with data 0x00, and status_wdata=0x1C in the same cycle.
- CLRF, ir_addr=STATUS, status_in=0xFF -> status_we only, status_wdata=0x04; gpr_we=0.
- Indirect with fsr_in=0x00, MOVWF -> no strobes at all; issue_ready behaves normally.
- Back-to-back issues with issue_valid held high -> accepts every 2 cycles; strobes never overlap, and each strobe lasts 1 cycle.
- rst_n low during RESOLVE -> no strobe afterward; all outputs 0 on the next cycle; issue_ready=1 one cycle after rst_n rises.
